// File: rtl/btb_set_assoc.sv
// Set-associative branch target buffer with a registered (1-cycle) lookup,
// commit-time training and per-set round-robin replacement.
// Optional feature macro: BTB_COUNTER_EN (2-bit saturating direction counters).
// Without it an entry predicts taken whenever it hits, and a not-taken
// conditional branch that hits drops its entry.
module btb_set_assoc #(
    parameter int SET_NUM = 64,
    parameter int WAY_NUM = 4,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              lookup_en,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic              pred_is_jump,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              update_en,
    input  logic [ADDR_W-1:0] update_pc,
    input  logic [ADDR_W-1:0] update_target,
    input  logic              update_is_jump,
    input  logic              update_taken
);

    localparam int INDEX_W = $clog2(SET_NUM);
    localparam int WAY_W   = (WAY_NUM > 1) ? $clog2(WAY_NUM) : 1;
    localparam int TAG_W   = ADDR_W - INDEX_W - 2;

    logic              valid_q  [SET_NUM][WAY_NUM];
    logic [TAG_W-1:0]  tag_q    [SET_NUM][WAY_NUM];
    logic [ADDR_W-1:0] target_q [SET_NUM][WAY_NUM];
    logic              jump_q   [SET_NUM][WAY_NUM];
    logic [WAY_W-1:0]  rr_q     [SET_NUM];
`ifdef BTB_COUNTER_EN
    logic [1:0]        ctr_q    [SET_NUM][WAY_NUM];
`endif

    // pc[1:0] never takes part in indexing or tagging
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0]};

    logic [INDEX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0]   lk_tag, up_tag;
    assign lk_idx = lookup_pc[INDEX_W+1:2];
    assign lk_tag = lookup_pc[ADDR_W-1:INDEX_W+2];
    assign up_idx = update_pc[INDEX_W+1:2];
    assign up_tag = update_pc[ADDR_W-1:INDEX_W+2];

    logic             lk_hit;
    logic [WAY_W-1:0] lk_way;
    logic             up_hit;
    logic [WAY_W-1:0] up_way;
    logic             up_any_inv;
    logic [WAY_W-1:0] up_inv_way;
    logic [WAY_W-1:0] victim;
    logic             alloc;

    // Tag compare for lookup and update; descending scan so the lowest way wins
    always_comb begin
        lk_hit     = 1'b0;
        lk_way     = '0;
        up_hit     = 1'b0;
        up_way     = '0;
        up_any_inv = 1'b0;
        up_inv_way = '0;
        for (int w = WAY_NUM - 1; w >= 0; w--) begin
            if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
                lk_hit = 1'b1;
                lk_way = WAY_W'(w);
            end
            if (valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag)) begin
                up_hit = 1'b1;
                up_way = WAY_W'(w);
            end
            if (!valid_q[up_idx][w]) begin
                up_any_inv = 1'b1;
                up_inv_way = WAY_W'(w);
            end
        end
        victim = up_any_inv ? up_inv_way : rr_q[up_idx];
        alloc  = !up_hit && (update_taken || update_is_jump);
    end

    // Registered prediction; reads pre-update contents, flush forces a miss
    always_ff @(posedge clk) begin
        if (!rst) begin
            pred_hit     <= 1'b0;
            pred_taken   <= 1'b0;
            pred_is_jump <= 1'b0;
            pred_target  <= '0;
        end else if (lookup_en) begin
            if (flush || !lk_hit) begin
                pred_hit     <= 1'b0;
                pred_taken   <= 1'b0;
                pred_is_jump <= 1'b0;
                pred_target  <= '0;
            end else begin
                pred_hit     <= 1'b1;
                pred_is_jump <= jump_q[lk_idx][lk_way];
                pred_target  <= target_q[lk_idx][lk_way];
`ifdef BTB_COUNTER_EN
                pred_taken   <= jump_q[lk_idx][lk_way] | ctr_q[lk_idx][lk_way][1];
`else
                pred_taken   <= 1'b1;
`endif
            end
        end
    end

    // Control state: valid bits, direction counters, replacement pointers
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < SET_NUM; s++) begin
                rr_q[s] <= '0;
                for (int w = 0; w < WAY_NUM; w++) begin
                    valid_q[s][w] <= 1'b0;
`ifdef BTB_COUNTER_EN
                    ctr_q[s][w]   <= 2'b00;
`endif
                end
            end
        end else if (flush) begin
            for (int s = 0; s < SET_NUM; s++) begin
                for (int w = 0; w < WAY_NUM; w++) begin
                    valid_q[s][w] <= 1'b0;
                end
            end
        end else if (update_en) begin
            if (up_hit) begin
`ifdef BTB_COUNTER_EN
                if (update_taken && (ctr_q[up_idx][up_way] != 2'b11))
                    ctr_q[up_idx][up_way] <= ctr_q[up_idx][up_way] + 2'b01;
                else if (!update_taken && (ctr_q[up_idx][up_way] != 2'b00))
                    ctr_q[up_idx][up_way] <= ctr_q[up_idx][up_way] - 2'b01;
`else
                if (!update_taken && !update_is_jump)
                    valid_q[up_idx][up_way] <= 1'b0;
`endif
            end else if (alloc) begin
                valid_q[up_idx][victim] <= 1'b1;
`ifdef BTB_COUNTER_EN
                ctr_q[up_idx][victim]   <= update_taken ? 2'b10 : 2'b01;
`endif
                if (!up_any_inv)
                    rr_q[up_idx] <= (WAY_NUM == 1) ? '0 : rr_q[up_idx] + 1'b1;
            end
        end
    end

    // Payload storage (tag/target/kind) needs no reset; guarded by valid
    always_ff @(posedge clk) begin
        if (rst && !flush && update_en) begin
            if (up_hit) begin
                target_q[up_idx][up_way] <= update_target;
                jump_q[up_idx][up_way]   <= update_is_jump;
            end else if (alloc) begin
                tag_q[up_idx][victim]    <= up_tag;
                target_q[up_idx][victim] <= update_target;
                jump_q[up_idx][victim]   <= update_is_jump;
            end
        end
    end

endmodule

// File: tb/tb_btb_set_assoc.sv
// Directed bench for btb_set_assoc at default parameters (64 sets, 4 ways, 32-bit PC).
module tb_btb_set_assoc;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        lookup_en;
    logic [31:0] lookup_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic        pred_is_jump;
    logic [31:0] pred_target;
    logic        update_en;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic        update_is_jump;
    logic        update_taken;

    int total = 0;
    int bad   = 0;

    btb_set_assoc dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .lookup_en      (lookup_en),
        .lookup_pc      (lookup_pc),
        .pred_hit       (pred_hit),
        .pred_taken     (pred_taken),
        .pred_is_jump   (pred_is_jump),
        .pred_target    (pred_target),
        .update_en      (update_en),
        .update_pc      (update_pc),
        .update_target  (update_target),
        .update_is_jump (update_is_jump),
        .update_taken   (update_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_pred(input string tag, input logic hit, input logic taken,
                            input logic jump, input logic [31:0] target);
        chk({tag, ".hit"},    {31'd0, pred_hit},     {31'd0, hit});
        chk({tag, ".taken"},  {31'd0, pred_taken},   {31'd0, taken});
        chk({tag, ".jump"},   {31'd0, pred_is_jump}, {31'd0, jump});
        chk({tag, ".target"}, pred_target,           target);
    endtask

    task automatic upd(input logic [31:0] pc, input logic [31:0] tgt,
                       input logic jump, input logic taken);
        update_en      = 1'b1;
        update_pc      = pc;
        update_target  = tgt;
        update_is_jump = jump;
        update_taken   = taken;
        tick();
        update_en      = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        lookup_en = 1'b1;
        lookup_pc = pc;
        tick();
        lookup_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; lookup_en = 1'b0; lookup_pc = '0;
        update_en = 1'b0; update_pc = '0; update_target = '0;
        update_is_jump = 1'b0; update_taken = 1'b0;
        tick(); tick();
        chk_pred("reset", 1'b0, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;

        // 1: cold lookup misses
        look(32'h0000_1000);
        chk_pred("cold", 1'b0, 1'b0, 1'b0, 32'h0);

        // 2: allocate taken branch, then hit
        upd(32'h1000, 32'h2000, 1'b0, 1'b1);
        look(32'h1000);
        chk_pred("alloc", 1'b1, 1'b1, 1'b0, 32'h2000);

        // outputs hold while lookup_en is low
        lookup_pc = 32'h0000_9990;
        tick();
        chk_pred("hold", 1'b1, 1'b1, 1'b0, 32'h2000);

        // 3: direction training
`ifdef BTB_COUNTER_EN
        upd(32'h1000, 32'h2000, 1'b0, 1'b0);
        upd(32'h1000, 32'h2000, 1'b0, 1'b0);
        look(32'h1000);
        chk_pred("nt2", 1'b1, 1'b0, 1'b0, 32'h2000);
        upd(32'h1000, 32'h2000, 1'b0, 1'b1);
        upd(32'h1000, 32'h2000, 1'b0, 1'b1);
        look(32'h1000);
        chk_pred("t2", 1'b1, 1'b1, 1'b0, 32'h2000);
`else
        upd(32'h1000, 32'h2000, 1'b0, 1'b0);
        look(32'h1000);
        chk_pred("nt_inval", 1'b0, 1'b0, 1'b0, 32'h0);
`endif

        // not-taken conditional miss allocates nothing
        upd(32'h0000_0700, 32'h5555, 1'b0, 1'b0);
        look(32'h0000_0700);
        chk_pred("no_alloc", 1'b0, 1'b0, 1'b0, 32'h0);

        // not-taken jump allocates and predicts taken
        upd(32'h0000_0704, 32'h7777, 1'b1, 1'b0);
        look(32'h0000_0704);
        chk_pred("jump", 1'b1, 1'b1, 1'b1, 32'h7777);

        // 4: round-robin replacement in set 0
        do_reset();
        for (int k = 1; k <= 5; k++) upd(32'(k) << 8, 32'(k) * 32'h10, 1'b0, 1'b1);
        look(32'h100);
        chk("rr.k1_evicted", {31'd0, pred_hit}, 32'd0);
        for (int k = 2; k <= 5; k++) begin
            look(32'(k) << 8);
            chk($sformatf("rr.k%0d_hit", k), {31'd0, pred_hit}, 32'd1);
            chk($sformatf("rr.k%0d_tgt", k), pred_target, 32'(k) * 32'h10);
        end
        upd(32'h600, 32'h60, 1'b0, 1'b1);
        look(32'h200);
        chk("rr.k2_evicted", {31'd0, pred_hit}, 32'd0);
        look(32'h300);
        chk("rr.k3_kept", {31'd0, pred_hit}, 32'd1);
        look(32'h600);
        chk_pred("rr.k6", 1'b1, 1'b1, 1'b0, 32'h60);

        // 5: read-before-write on same entry
        do_reset();
        upd(32'h3000, 32'h1111, 1'b0, 1'b1);
        lookup_en = 1'b1; lookup_pc = 32'h3000;
        update_en = 1'b1; update_pc = 32'h3000; update_target = 32'h4000;
        update_is_jump = 1'b0; update_taken = 1'b1;
        tick();
        lookup_en = 1'b0; update_en = 1'b0;
        chk_pred("rbw.old", 1'b1, 1'b1, 1'b0, 32'h1111);
        look(32'h3002);
        chk_pred("rbw.new", 1'b1, 1'b1, 1'b0, 32'h4000);

        // 6: flush beats simultaneous update and lookup
        upd(32'h104, 32'hA1, 1'b0, 1'b1);
        upd(32'h208, 32'hA2, 1'b0, 1'b1);
        look(32'h104);
        chk("pre_flush.hit", {31'd0, pred_hit}, 32'd1);
        flush = 1'b1;
        lookup_en = 1'b1; lookup_pc = 32'h104;
        update_en = 1'b1; update_pc = 32'h30C; update_target = 32'hA3;
        update_is_jump = 1'b0; update_taken = 1'b1;
        tick();
        flush = 1'b0; lookup_en = 1'b0; update_en = 1'b0;
        chk_pred("flush.cycle", 1'b0, 1'b0, 1'b0, 32'h0);
        look(32'h3000); chk("flush.3000", {31'd0, pred_hit}, 32'd0);
        look(32'h104);  chk("flush.104",  {31'd0, pred_hit}, 32'd0);
        look(32'h208);  chk("flush.208",  {31'd0, pred_hit}, 32'd0);
        look(32'h30C);  chk("flush.30C",  {31'd0, pred_hit}, 32'd0);

        // 7: reset mid-operation drops the update and clears outputs
        upd(32'h410, 32'hB0, 1'b0, 1'b1);
        look(32'h410);
        chk("pre_rst.hit", {31'd0, pred_hit}, 32'd1);
        rst = 1'b0;
        update_en = 1'b1; update_pc = 32'h514; update_target = 32'hB1;
        update_is_jump = 1'b1; update_taken = 1'b1;
        tick();
        rst = 1'b1; update_en = 1'b0;
        chk_pred("rst.mid", 1'b0, 1'b0, 1'b0, 32'h0);
        look(32'h514); chk("rst.drop", {31'd0, pred_hit}, 32'd0);
        look(32'h410); chk("rst.clear", {31'd0, pred_hit}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
